// File: rtl/pulp_sync_edge_filter.sv
// Multi-channel input synchroniser with a programmable stability filter,
// registered edge pulses and sticky rising/falling event flags.
module pulp_sync_edge_filter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT_W = 4
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [NUM_CH-1:0] serial_i,
  input  logic [NUM_CH-1:0] evt_mask_i,
  input  logic [NUM_CH-1:0] clr_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] r_edge_o,
  output logic [NUM_CH-1:0] f_edge_o,
  output logic [NUM_CH-1:0] pend_r_o,
  output logic [NUM_CH-1:0] pend_f_o,
  output logic              irq_o
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              r_edge_q, r_edge_d;
    logic              f_edge_q, f_edge_d;
    logic              pend_r_q, pend_f_q;
    logic              s;

    // The synchroniser runs regardless of en_i so it is already settled when filtering resumes.
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], serial_i[ch]};
    end

    assign s = sync_q[STAGES-1];

    always_comb begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      r_edge_d = 1'b0;
      f_edge_d = 1'b0;
      if (en_i) begin
        if (s == level_q) begin
          cnt_d = '0;
        end else if (cnt_q >= filt_len_i) begin
          level_d  = s;
          cnt_d    = '0;
          r_edge_d = s;
          f_edge_d = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Sticky flags: a new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt_q    <= '0;
        level_q  <= 1'b0;
        r_edge_q <= 1'b0;
        f_edge_q <= 1'b0;
        pend_r_q <= 1'b0;
        pend_f_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        r_edge_q <= r_edge_d;
        f_edge_q <= f_edge_d;
        pend_r_q <= r_edge_d | (pend_r_q & ~clr_i[ch]);
        pend_f_q <= f_edge_d | (pend_f_q & ~clr_i[ch]);
      end
    end

    assign level_o[ch]  = level_q;
    assign r_edge_o[ch] = r_edge_q;
    assign f_edge_o[ch] = f_edge_q;
    assign pend_r_o[ch] = pend_r_q;
    assign pend_f_o[ch] = pend_f_q;
  end

  assign irq_o = |((pend_r_o | pend_f_o) & evt_mask_i);

endmodule

// File: tb/tb_pulp_sync_edge_filter.sv
// Self-checking bench for pulp_sync_edge_filter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_pulp_sync_edge_filter;
  localparam int NUM_CH = 4;
  localparam int STAGES = 2;
  localparam int FILT_W = 4;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic              en_i;
  logic [FILT_W-1:0] filt_len_i;
  logic [NUM_CH-1:0] serial_i;
  logic [NUM_CH-1:0] evt_mask_i;
  logic [NUM_CH-1:0] clr_i;
  logic [NUM_CH-1:0] level_o, r_edge_o, f_edge_o, pend_r_o, pend_f_o;
  logic              irq_o;

  int checks   = 0;
  int failures = 0;

  // Model: input history for the synchroniser delay, plus the count of consecutive
  // enabled cycles the synchronised input has disagreed with the accepted level.
  bit              m_hist [NUM_CH][STAGES];
  int              m_run  [NUM_CH];
  bit [NUM_CH-1:0] m_level, m_r, m_f, m_pr, m_pf;

  pulp_sync_edge_filter #(.NUM_CH(NUM_CH), .STAGES(STAGES), .FILT_W(FILT_W)) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .filt_len_i (filt_len_i),
    .serial_i   (serial_i),
    .evt_mask_i (evt_mask_i),
    .clr_i      (clr_i),
    .level_o    (level_o),
    .r_edge_o   (r_edge_o),
    .f_edge_o   (f_edge_o),
    .pend_r_o   (pend_r_o),
    .pend_f_o   (pend_f_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < STAGES; k++) m_hist[ch][k] = 1'b0;
      m_run[ch] = 0;
    end
    m_level = '0; m_r = '0; m_f = '0; m_pr = '0; m_pf = '0;
  endtask

  task automatic model_update();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit s, r, f;
      s = m_hist[ch][STAGES-1];
      r = 1'b0;
      f = 1'b0;
      if (en_i) begin
        if (s == m_level[ch]) m_run[ch] = 0;
        else if (m_run[ch] >= int'(filt_len_i)) begin
          m_level[ch] = s;
          m_run[ch]   = 0;
          r = s;
          f = !s;
        end else m_run[ch]++;
      end
      m_r[ch]  = r;
      m_f[ch]  = f;
      m_pr[ch] = r || (m_pr[ch] && !clr_i[ch]);
      m_pf[ch] = f || (m_pf[ch] && !clr_i[ch]);
      for (int k = STAGES-1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = serial_i[ch];
    end
  endtask

  task automatic check_output(input string tag);
    chk({tag, "_level"},  32'(level_o),  32'(m_level));
    chk({tag, "_redge"},  32'(r_edge_o), 32'(m_r));
    chk({tag, "_fedge"},  32'(f_edge_o), 32'(m_f));
    chk({tag, "_pend_r"}, 32'(pend_r_o), 32'(m_pr));
    chk({tag, "_pend_f"}, 32'(pend_f_o), 32'(m_pf));
    chk({tag, "_irq"},    32'(irq_o),    32'(|((m_pr | m_pf) & evt_mask_i)));
  endtask

  // One clock with the currently driven inputs; outputs checked 1 time unit after the edge.
  task automatic apply_stimulus(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_output(tag);
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(tag);
  endtask

  initial begin
    rstn_i = 1'b0; en_i = 1'b1; filt_len_i = '0;
    serial_i = '0; evt_mask_i = '1; clr_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset");
    rstn_i = 1'b1;
    run_cycles(4, "idle");

    $display("[TB] T1 unfiltered rising edge latency");
    serial_i[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus("t1");
      if (i == 2) chk("t1_redge_early", 32'(r_edge_o[0]), 32'd0);
      if (i == 3) begin
        chk("t1_redge_at3", 32'(r_edge_o[0]), 32'd1);
        chk("t1_pend_r",    32'(pend_r_o[0]), 32'd1);
      end
      if (i == 4) chk("t1_redge_once", 32'(r_edge_o[0]), 32'd0);
    end

    $display("[TB] T2 glitch rejection with filt_len=3");
    filt_len_i = 4'd3;
    serial_i[1] = 1'b1;
    run_cycles(3, "t2_glitch");
    serial_i[1] = 1'b0;
    run_cycles(8, "t2_quiet");
    chk("t2_level_glitch", 32'(level_o[1]), 32'd0);
    serial_i[1] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      apply_stimulus("t2");
      if (i == STAGES + 3) chk("t2_redge_early", 32'(r_edge_o[1]), 32'd0);
      if (i == STAGES + 4) chk("t2_redge_at6",   32'(r_edge_o[1]), 32'd1);
    end

    $display("[TB] T3 sticky set wins over clear");
    filt_len_i = 4'd0;
    serial_i[2] = 1'b1; run_cycles(5, "t3_up");
    serial_i[2] = 1'b0; run_cycles(5, "t3_down");
    serial_i[2] = 1'b1; run_cycles(5, "t3_up2");
    serial_i[2] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      clr_i = (i == 3) ? 4'b0100 : 4'b0000;
      apply_stimulus("t3");
      if (i == 3) begin
        chk("t3_fedge",      32'(f_edge_o[2]), 32'd1);
        chk("t3_set_wins",   32'(pend_f_o[2]), 32'd1);
      end
    end
    clr_i = 4'b0100;
    apply_stimulus("t3_clr");
    chk("t3_cleared", 32'(pend_f_o[2]), 32'd0);
    clr_i = '0;

    $display("[TB] T4 enable gating");
    filt_len_i = 4'd2;
    run_cycles(6, "t4_settle");
    en_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      serial_i[3] = ~serial_i[3];
      apply_stimulus("t4_off");
    end
    serial_i[3] = 1'b1;
    run_cycles(STAGES + 2, "t4_off_settle");
    chk("t4_level_held", 32'(level_o[3]), 32'd0);
    en_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus("t4_on");
      if (i == 2) chk("t4_redge_early", 32'(r_edge_o[3]), 32'd0);
      if (i == 3) chk("t4_redge_at3",   32'(r_edge_o[3]), 32'd1);
    end

    $display("[TB] T5 interrupt masking");
    clr_i = '1;
    apply_stimulus("t5_clrall");
    clr_i = '0;
    evt_mask_i = 4'b0010;
    filt_len_i = 4'd0;
    serial_i[1:0] = 2'b00;
    run_cycles(5, "t5_events");
    chk("t5_irq_set", 32'(irq_o), 32'd1);
    clr_i = 4'b0010;
    apply_stimulus("t5_clr1");
    clr_i = '0;
    chk("t5_irq_clear", 32'(irq_o), 32'd0);
    chk("t5_pend0",     32'(pend_f_o[0]), 32'd1);

    $display("[TB] T6 asynchronous reset mid-filter");
    filt_len_i = 4'd3;
    serial_i[0] = 1'b1;
    run_cycles(10, "t6_up");
    serial_i[0] = 1'b0;
    run_cycles(4, "t6_count");
    #1;
    rstn_i = 1'b0;
    model_reset();
    #1;
    check_output("t6_in_reset");
    chk("t6_level_zero", 32'(level_o), 32'd0);
    serial_i = '0;
    #1;
    rstn_i = 1'b1;
    run_cycles(8, "t6_release");

    $display("[TB] Randomized traffic");
    evt_mask_i = '1;
    for (int blk = 0; blk < 4; blk++) begin
      en_i = 1'b1;
      clr_i = '0;
      run_cycles(STAGES + 18, "rnd_settle");
      filt_len_i = FILT_W'($urandom_range(0, 3));
      for (int i = 0; i < 150; i++) begin
        for (int ch = 0; ch < NUM_CH; ch++)
          if ($urandom_range(0, 3) == 0) serial_i[ch] = ~serial_i[ch];
        en_i = ($urandom_range(0, 7) != 0);
        for (int ch = 0; ch < NUM_CH; ch++)
          clr_i[ch] = ($urandom_range(0, 7) == 0);
        evt_mask_i = NUM_CH'($urandom);
        apply_stimulus("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
